// File: rtl/hidden_bios_memory.sv
// Hidden-layer bias ROM: ten elaboration-time 8-bit biases, presented in parallel after a trigger and held until reset.
// Latency: outputs valid one clk after the first edge that samples t=1; no backpressure, no write path.
module hidden_bios_memory #(
    parameter logic [7:0] BIAS0 = 8'h12,
    parameter logic [7:0] BIAS1 = 8'hF0,
    parameter logic [7:0] BIAS2 = 8'h05,
    parameter logic [7:0] BIAS3 = 8'hE7,
    parameter logic [7:0] BIAS4 = 8'h20,
    parameter logic [7:0] BIAS5 = 8'h00,
    parameter logic [7:0] BIAS6 = 8'hFF,
    parameter logic [7:0] BIAS7 = 8'h7F,
    parameter logic [7:0] BIAS8 = 8'h80,
    parameter logic [7:0] BIAS9 = 8'h33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       t,
    output logic [7:0] res0,
    output logic [7:0] res1,
    output logic [7:0] res2,
    output logic [7:0] res3,
    output logic [7:0] res4,
    output logic [7:0] res5,
    output logic [7:0] res6,
    output logic [7:0] res7,
    output logic [7:0] res8,
    output logic [7:0] res9
);

    localparam int NUM_BIAS = 10;

    localparam logic [7:0] ROM [NUM_BIAS] = '{
        BIAS0, BIAS1, BIAS2, BIAS3, BIAS4,
        BIAS5, BIAS6, BIAS7, BIAS8, BIAS9
    };

    // The state register doubles as the internal loaded flag.
    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       load_en;
    logic [7:0] bias_q [NUM_BIAS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        case (state)
            EMPTY: begin
                if (t) begin
                    state_nxt = LOADED;
                    load_en   = 1'b1;
                end
            end
            LOADED: begin
                state_nxt = LOADED;
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Loading only from EMPTY makes re-triggers a no-op on the output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BIAS; k++) begin
                bias_q[k] <= 8'h00;
            end
        end else if (load_en) begin
            for (int k = 0; k < NUM_BIAS; k++) begin
                bias_q[k] <= ROM[k];
            end
        end
    end

    assign res0 = bias_q[0];
    assign res1 = bias_q[1];
    assign res2 = bias_q[2];
    assign res3 = bias_q[3];
    assign res4 = bias_q[4];
    assign res5 = bias_q[5];
    assign res6 = bias_q[6];
    assign res7 = bias_q[7];
    assign res8 = bias_q[8];
    assign res9 = bias_q[9];

endmodule

// File: tb/tb_hidden_bios_memory.sv
// Bench for hidden_bios_memory: default-parameter and overridden instances driven in lockstep against a queued reference.
module tb_hidden_bios_memory;

    logic       clk;
    logic       rst_n;
    logic       t;

    logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8, b9;
    logic [79:0] obs_a;
    logic [79:0] obs_b;

    logic [79:0] def_v;
    logic [79:0] ovr_v;
    logic [79:0] exp_a_q [$];
    logic [79:0] exp_b_q [$];

    int  vectors;
    int  miscompares;
    bit  model_loaded;

    hidden_bios_memory dut_def (
        .clk(clk), .rst_n(rst_n), .t(t),
        .res0(a0), .res1(a1), .res2(a2), .res3(a3), .res4(a4),
        .res5(a5), .res6(a6), .res7(a7), .res8(a8), .res9(a9)
    );

    hidden_bios_memory #(
        .BIAS3(8'h5A),
        .BIAS9(8'hC1)
    ) dut_ovr (
        .clk(clk), .rst_n(rst_n), .t(t),
        .res0(b0), .res1(b1), .res2(b2), .res3(b3), .res4(b4),
        .res5(b5), .res6(b6), .res7(b7), .res8(b8), .res9(b9)
    );

    assign obs_a = {a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
    assign obs_b = {b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        for (int k = 0; k < 10; k++) begin
            vectors++;
            assert (obs[k*8 +: 8] === exp[k*8 +: 8]) else begin
                miscompares++;
                $error("FAIL %s res%0d observed=%h expected=%h", tag, k, obs[k*8 +: 8], exp[k*8 +: 8]);
            end
        end
    endtask

    task automatic push_expected();
        exp_a_q.push_back(model_loaded ? def_v : 80'h0);
        exp_b_q.push_back(model_loaded ? ovr_v : 80'h0);
    endtask

    task automatic pop_and_check(input string tag);
        logic [79:0] ea;
        logic [79:0] eb;
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        check_vec({tag, "/def"}, obs_a, ea);
        check_vec({tag, "/ovr"}, obs_b, eb);
    endtask

    // One clock: drive at negedge, update the reference, compare just after the rising edge.
    task automatic step(input string tag, input logic r, input logic tr);
        @(negedge clk);
        rst_n = r;
        t     = tr;
        if (!r) model_loaded = 1'b0;
        else if (tr) model_loaded = 1'b1;
        push_expected();
        @(posedge clk);
        #1;
        pop_and_check(tag);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        model_loaded = 1'b0;
        def_v = {8'h33, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h20, 8'hE7, 8'h05, 8'hF0, 8'h12};
        ovr_v = {8'hC1, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h20, 8'h5A, 8'h05, 8'hF0, 8'h12};
        rst_n = 1'b0;
        t     = 1'b0;

        for (int i = 0; i < 3; i++)  step("reset", 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("idle", 1'b1, 1'b0);
        step("load", 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step("hold", 1'b1, 1'b0);

        // Reset low between edges only: must not disturb the loaded outputs.
        #1;
        rst_n = 1'b0;
        #2;
        push_expected();
        pop_and_check("rst_between_edges");
        rst_n = 1'b1;
        step("after_glitch", 1'b1, 1'b0);

        step("collision", 1'b0, 1'b1);
        step("collision_reload", 1'b1, 1'b1);
        step("retrigger_off", 1'b1, 1'b0);

        step("reset_loaded", 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("t_held", 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("t_drop", 1'b1, 1'b0);

        step("final_reset", 1'b0, 1'b0);
        step("final_idle", 1'b1, 1'b0);
        step("final_load", 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hidden_bios_memory.md
# hidden_bios_memory

Read-only store for the ten 8-bit hidden-layer bias values of the neural-network datapath. After a trigger, it presents all ten biases in parallel as registered outputs to the hidden-layer neuron/accumulator stage, and holds them until reset. The contents are fixed at elaboration through parameters. There is no write path.

## Interface
Parameters (8-bit two's-complement bias constants):
- BIAS0, 8'h12, bias for hidden neuron 0
- BIAS1, 8'hF0, bias for hidden neuron 1
- BIAS2, 8'h05, bias for hidden neuron 2
- BIAS3, 8'hE7, bias for hidden neuron 3
- BIAS4, 8'h20, bias for hidden neuron 4
- BIAS5, 8'h00, bias for hidden neuron 5
- BIAS6, 8'hFF, bias for hidden neuron 6
- BIAS7, 8'h7F, bias for hidden neuron 7
- BIAS8, 8'h80, bias for hidden neuron 8
- BIAS9, 8'h33, bias for hidden neuron 9

Ports:
- One clock; reset is synchronous and active-low.
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset
- t  input  1  load trigger; level-sampled on each rising clk edge
- res0 … res9  output  8 each  registered bias values for neurons 0–9 (two's complement)

## Operation
- Internal ROM: a 10-entry × 8-bit table. Entry k = BIASk.
- Output registers: ten 8-bit registers, driving res0–res9 directly. No combinational path from t to the outputs.
- Internal `loaded` flag: 1 bit, not a port.
- State machine, two states:
  - EMPTY: the reset state. Outputs are all 8'h00.
  - LOADED: outputs equal ROM contents.
- Transitions:
  - EMPTY → LOADED on a rising edge with rst_n=1 and t=1. On that same edge, every resk register takes BIASk.
  - LOADED → LOADED regardless of t. Outputs do not change, so re-triggering is harmless and idempotent.
  - Any state → EMPTY on a rising edge with rst_n=0.
- Dropping t back to 0 does not clear or alter the outputs.
- All ten outputs update on the same edge. There is no partial or sequential load.
- Values pass through unmodified: no sign extension, no arithmetic.

## Timing
- Reset value of every output: 8'h00. The `loaded` flag resets to 0.
- Reset is synchronous and takes effect only at a rising clk edge with rst_n=0. Asserting rst_n asynchronously between edges has no effect.
- Load latency: outputs show the biases 1 clock after the first edge that samples t=1 (i.e. valid right after that edge).
- rst_n=0 and t=1 on the same edge: reset wins and outputs become 8'h00.
- Reset mid-operation (in LOADED): outputs return to 8'h00 on the reset edge.
- Re-trigger after reset: the next edge with rst_n=1 and t=1 reloads the ROM values.
- t must be synchronous to clk. A pulse of at least one full cycle that spans a rising edge is required.
- Outputs are stable between edges and glitch-free.

## Test plan
- Reset: rst_n=0 for 3 cycles with t=0 → res0–res9 all 8'h00.
- Idle: rst_n=1, t=0 for 10 cycles → outputs stay 8'h00.
- Load: t=1 for one cycle → after that edge, outputs are 12,F0,05,E7,20,00,FF,7F,80,33 (res0→res9). Then t=0 for 20 cycles → values held unchanged.
- Collision: rst_n=0 and t=1 on the same edge → all outputs 8'h00. On the next edge with rst_n=1, t=1 → default biases appear.
- Reset while loaded: after load, pulse rst_n=0 for one cycle → outputs 8'h00. Hold t=1 continuously afterward → reload on the first edge with rst_n=1; repeated t=1 keeps outputs constant.
- Parameter override: instantiate with BIAS3=8'h5A, BIAS9=8'hC1 and trigger → res3=8'h5A, res9=8'hC1, others at their defaults.
